// File: rtl/mul_div_execute_pkg.sv
// Shared constants for the iterative M-extension execute unit:
// operand width, funct3 opcodes, iteration counter limits and FSM encoding.
package mul_div_execute_pkg;

    localparam int MD_XLEN = 32;
    localparam int CNT_W   = 5;
    localparam logic [CNT_W-1:0] CNT_LAST = 5'd31;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } md_state_e;

endpackage

// File: rtl/mul_div_execute_if.sv
// Pipeline-side bundle of the mul/div unit: EX-stage request in, stall/result out.
interface mul_div_execute_if
    import mul_div_execute_pkg::*;
#(
    parameter int XLEN = MD_XLEN
);
    logic            clr;
    logic            start_EX;
    logic [2:0]      funct3_EX;
    logic [XLEN-1:0] operandA_EX;
    logic [XLEN-1:0] operandB_EX;
    logic [4:0]      writeAddress_EX;
    logic            busy;
    logic            done;
    logic [XLEN-1:0] result;
    logic [4:0]      writeAddress_MD;

    modport master (
        output clr, start_EX, funct3_EX, operandA_EX, operandB_EX, writeAddress_EX,
        input  busy, done, result, writeAddress_MD
    );

    modport slave (
        input  clr, start_EX, funct3_EX, operandA_EX, operandB_EX, writeAddress_EX,
        output busy, done, result, writeAddress_MD
    );
endinterface

// File: rtl/mul_div_step.sv
// One radix-2 iteration on magnitudes: shift-add multiply or restoring divide.
// {acc_hi, acc_lo} holds partial product / {remainder, dividend-quotient}.
module mul_div_step #(
    parameter int XLEN = 32
) (
    input  logic            is_div,
    input  logic [XLEN-1:0] acc_hi,
    input  logic [XLEN-1:0] acc_lo,
    input  logic [XLEN-1:0] op_b,
    output logic [XLEN-1:0] hi_nxt,
    output logic [XLEN-1:0] lo_nxt
);
    logic [XLEN:0]   sum;
    logic [XLEN:0]   shifted;
    logic [XLEN-1:0] trial;
    logic            ge;

    always_comb begin
        sum     = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, op_b} : '0);
        shifted = {acc_hi, acc_lo[XLEN-1]};
        ge      = shifted >= {1'b0, op_b};
        // remainder stays below op_b, so the true difference fits in XLEN bits
        trial   = shifted[XLEN-1:0] - op_b;
        if (is_div) begin
            hi_nxt = ge ? trial : shifted[XLEN-1:0];
            lo_nxt = {acc_lo[XLEN-2:0], ge};
        end else begin
            hi_nxt = sum[XLEN:1];
            lo_nxt = {sum[0], acc_lo[XLEN-1:1]};
        end
    end
endmodule

// File: rtl/mul_div_execute.sv
// Iterative RV32M execute unit: fixed 32-iteration latency for every op,
// stalls the front of the pipe while busy, result registered on entry to DONE.
//
// state   | meaning
// IDLE    | waiting for start_EX; accept captures operands and clears counter
// BUSY    | one multiply/divide iteration per cycle, counter 0..31
// DONE    | done pulse, result valid, pipeline released
module mul_div_execute
    import mul_div_execute_pkg::*;
#(
    parameter int XLEN = MD_XLEN
) (
    input logic             clk,
    input logic             rst_n,
    mul_div_execute_if.slave md
);
    md_state_e        state, state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       op_q;
    logic             neg_a_q, neg_b_q, b_zero_q;
    logic [XLEN-1:0]  acc_hi, acc_lo, op_b;
    logic [4:0]       wa_q;
    logic [XLEN-1:0]  result_q;
    logic [4:0]       wa_md_q;

    logic             accept, iterate, finish;
    logic             signed_a, signed_b, a_neg, b_neg, neg_p;
    logic [XLEN-1:0]  mag_a, mag_b;
    logic [XLEN-1:0]  hi_nxt, lo_nxt;
    logic [2*XLEN-1:0] prod, prod_fix;
    logic [XLEN-1:0]  res_fix;

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        iterate   = 1'b0;
        finish    = 1'b0;
        if (md.clr) begin
            state_nxt = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: if (md.start_EX) begin
                    accept    = 1'b1;
                    state_nxt = ST_BUSY;
                end
                ST_BUSY: begin
                    iterate = 1'b1;
                    if (cnt == CNT_LAST) begin
                        finish    = 1'b1;
                        state_nxt = ST_DONE;
                    end
                end
                ST_DONE: state_nxt = ST_IDLE;
                default: state_nxt = ST_IDLE;
            endcase
        end
    end

    assign md.busy = rst_n & ~md.clr &
                     (((state == ST_IDLE) & md.start_EX) | (state == ST_BUSY));
    assign md.done            = (state == ST_DONE);
    assign md.result          = result_q;
    assign md.writeAddress_MD = wa_md_q;

    always_comb begin
        signed_a = md.funct3_EX inside {F3_MULH, F3_MULHSU, F3_DIV, F3_REM};
        signed_b = md.funct3_EX inside {F3_MULH, F3_DIV, F3_REM};
        a_neg    = signed_a & md.operandA_EX[XLEN-1];
        b_neg    = signed_b & md.operandB_EX[XLEN-1];
        mag_a    = a_neg ? -md.operandA_EX : md.operandA_EX;
        mag_b    = b_neg ? -md.operandB_EX : md.operandB_EX;
    end

    mul_div_step #(.XLEN(XLEN)) u_step (
        .is_div (op_q[2]),
        .acc_hi (acc_hi),
        .acc_lo (acc_lo),
        .op_b   (op_b),
        .hi_nxt (hi_nxt),
        .lo_nxt (lo_nxt)
    );

    // Sign fix-up works on the last iteration's output so it lands in result on the DONE edge
    always_comb begin
        neg_p    = neg_a_q ^ neg_b_q;
        prod     = {hi_nxt, lo_nxt};
        prod_fix = neg_p ? -prod : prod;
        case (op_q)
            F3_MUL:                      res_fix = prod_fix[XLEN-1:0];
            F3_MULH, F3_MULHSU, F3_MULHU: res_fix = prod_fix[2*XLEN-1:XLEN];
            F3_DIV, F3_DIVU:             res_fix = b_zero_q ? '1 : (neg_p ? -lo_nxt : lo_nxt);
            default:                     res_fix = neg_a_q ? -hi_nxt : hi_nxt;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            op_q     <= '0;
            neg_a_q  <= 1'b0;
            neg_b_q  <= 1'b0;
            b_zero_q <= 1'b0;
            acc_hi   <= '0;
            acc_lo   <= '0;
            op_b     <= '0;
            wa_q     <= '0;
            result_q <= '0;
            wa_md_q  <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                op_q     <= md.funct3_EX;
                neg_a_q  <= a_neg;
                neg_b_q  <= b_neg;
                b_zero_q <= (md.operandB_EX == '0);
                acc_hi   <= '0;
                acc_lo   <= mag_a;
                op_b     <= mag_b;
                wa_q     <= md.writeAddress_EX;
                cnt      <= '0;
            end else if (iterate) begin
                acc_hi <= hi_nxt;
                acc_lo <= lo_nxt;
                cnt    <= cnt + 1'b1;
            end
            if (finish) begin
                result_q <= res_fix;
                wa_md_q  <= wa_q;
            end
        end
    end
endmodule

// File: doc/mul_div_execute.md
MUL_DIV_EXECUTE -- requirements
Module: mul_div_execute

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-low reset; ports SHALL be listed clock and reset first.
REQ-002 Parameter XLEN, default 32, SHALL be the operand and result width.
REQ-003 clk  input  1  rising-edge clock.
REQ-004 rst_n  input  1  synchronous active-low reset.
REQ-005 clr  input  1  pipeline flush, active-high; aborts any operation.
REQ-006 start_EX  input  1  M-extension instruction present in EX.
REQ-007 funct3_EX  input  3  operation select.
REQ-008 operandA_EX  input  XLEN  forwarded rs1 value.
REQ-009 operandB_EX  input  XLEN  forwarded rs2 value.
REQ-010 writeAddress_EX  input  5  destination register.
REQ-011 busy  output  1  stall request to the IF/ID and ID/EX registers.
REQ-012 done  output  1  one-cycle pulse; result valid.
REQ-013 result  output  XLEN  operation result.
REQ-014 writeAddress_MD  output  5  destination captured at accept.

Function
REQ-015 funct3 SHALL decode as: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-016 FSM states SHALL be IDLE, BUSY and DONE.
REQ-017 Accept: IDLE with start_EX=1 and clr=0 SHALL capture the operands, funct3 and writeAddress_EX, clear a 5-bit counter, and go to BUSY.
REQ-018 BUSY SHALL perform one radix-2 iteration per cycle on operand magnitudes: shift-add for multiply, restoring for divide.
REQ-019 BUSY SHALL go to DONE when the counter equals 31; all operations have a fixed latency: done is high exactly 33 cycles after the accept edge.
REQ-020 DONE SHALL assert done=1 for one cycle, then go to IDLE.
REQ-021 busy SHALL be a combinational OR of (IDLE and start_EX and not clr) and (BUSY and not clr); busy SHALL be 0 in DONE, so the pipeline advances in the DONE cycle.
REQ-022 Operand changes during BUSY or DONE SHALL be ignored.
REQ-023 A start_EX seen in DONE SHALL NOT be accepted; it is accepted on the following IDLE cycle.
REQ-024 Multiply SHALL form a 2*XLEN product.
REQ-025 Multiply result selection: MUL SHALL return the low half; MULH, MULHSU and MULHU SHALL return the high half, with signed×signed, signed×unsigned and unsigned×unsigned sign fix-up respectively.
REQ-026 Divide sign: the quotient sign SHALL be signA XOR signB and the remainder sign SHALL be signA, for DIV and REM only.
REQ-027 Divide by zero: the quotient SHALL be all ones and the remainder SHALL be the dividend.
REQ-028 Signed overflow (0x80000000 / -1): the quotient SHALL be 0x80000000 and the remainder SHALL be 0; the latency is unchanged.
REQ-029 result and writeAddress_MD SHALL be registered, update on entry to DONE, and hold until the next entry to DONE.
REQ-030 clr=1 in any state SHALL force IDLE on the next edge with done=0; result SHALL hold its value.
REQ-031 rst_n has priority over clr, and clr has priority over start_EX.

Reset
REQ-032 With rst_n=0 at an edge, the block SHALL take these values: state IDLE, counter 0, done 0, result 0, writeAddress_MD 0, internal operand and accumulator registers 0.
REQ-033 busy SHALL be 0 while rst_n=0.
REQ-034 Reset during BUSY SHALL abandon the operation without producing a done pulse.

Structure
REQ-035 The funct3 opcode constants, XLEN and the state encodings SHALL reside in the shared core package.
REQ-036 One combinational sub-module, mul_div_step, SHALL implement a single shift-add / restore-subtract iteration; the FSM, counter and sign fix-up SHALL reside in mul_div_execute.

Verification
REQ-037 MUL: A=7, B=0xFFFFFFFD -> busy high from the accept cycle through cycle 32, done at cycle 33, result 0xFFFFFFEB.
REQ-038 MULHU and MULH: A=B=0xFFFFFFFF -> MULHU result 0xFFFFFFFE; MULH result 0x00000000.
REQ-039 Signed divide: DIV A=0xFFFFFFF9, B=2 -> result 0xFFFFFFFD; REM with the same operands -> result 0xFFFFFFFF.
REQ-040 Divide corners: DIVU 5/0 -> 0xFFFFFFFF; REMU 5/0 -> 5; DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM with the same operands -> 0.
REQ-041 Flush: clr at cycle 10 of BUSY -> busy 0 in that cycle, no done, state IDLE; a subsequent MUL 3*4 -> 12 with nominal latency.
REQ-042 Reset mid-operation: rst_n low at cycle 5 of BUSY -> all outputs 0 after the edge and no done pulse; back-to-back starts -> the second is accepted on the cycle after DONE.
